// File: rtl/dmem_pkg.sv
// Shared types and defaults for the MEM-stage data-memory responder.
// The optional range check is enabled by defining DMEM_RANGE_CHECK_EN.
package dmem_pkg;

    localparam int unsigned DefDepthWords = 64;
    localparam int unsigned DefAddrBase   = 1024;
    localparam int unsigned DefWaitCycles = 3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StDone = 2'd2
    } state_e;

    typedef enum logic {
        OpRead  = 1'b0,
        OpWrite = 1'b1
    } op_e;

    // Word number relative to the base; the caller truncates to the array index width.
    // The 32-bit subtraction wraps, so addresses below the base land at the top.
    function automatic logic [31:0] calc_word_idx(input logic [31:0] byte_addr,
                                                  input logic [31:0] base_addr);
        logic [31:0] offset;
        offset = byte_addr - base_addr;
        return offset >> 2;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, DEPTH_WORDS x 32. Read data is registered every
// cycle from the current index (old data on a same-cycle write). No reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DefDepthWords,
    parameter int unsigned IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Write port and registered read port share the same index.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        rdata <= mem[idx];
    end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: serves one read or write at a time with a
// fixed programmable latency and a combinational ready handshake that freezes
// the pipeline while an access is in flight.
// Optional feature: define DMEM_RANGE_CHECK_EN to add the err output, drop
// out-of-range writes and return zero for out-of-range reads.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DefDepthWords,
    parameter int unsigned ADDR_BASE   = DefAddrBase,
    parameter int unsigned WAIT_CYCLES = DefWaitCycles
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        ready
`ifdef DMEM_RANGE_CHECK_EN
    ,
    output logic        err
`endif
);

    localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CntW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q;
    op_e               op_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rd_data_q;

    logic              req;
    logic              in_range;
    logic              arr_we;
    logic [IdxW-1:0]   arr_idx;
    logic [31:0]       arr_rdata;

    assign req     = mem_r_en | mem_w_en;
    assign arr_idx = IdxW'(calc_word_idx(addr_q, ADDR_BASE));

`ifdef DMEM_RANGE_CHECK_EN
    logic [31:0] byte_off;
    assign byte_off = addr_q - ADDR_BASE;
    assign in_range = (byte_off < DEPTH_WORDS * 4);
`else
    // Without the check every address wraps into the array.
    assign in_range = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept in IDLE, count down in WAIT, one ready cycle in DONE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs: handshake, array write strobe and read-data presentation.
    always_comb begin
        ready   = ((state_q == StIdle) && !req) || (state_q == StDone);
        arr_we  = (state_q == StWait) && (cnt_q == '0) && (op_q == OpWrite) && in_range;
        rd_data = rd_data_q;
        // The array read lands on the WAIT->DONE edge, so show it straight through in DONE.
        if ((state_q == StDone) && (op_q == OpRead)) begin
            rd_data = in_range ? arr_rdata : '0;
        end
`ifdef DMEM_RANGE_CHECK_EN
        err = (state_q == StDone) && !in_range;
`endif
    end

    // Request latches, latency counter and held read data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            op_q      <= OpRead;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_data_q <= '0;
        end else begin
            if ((state_q == StIdle) && req) begin
                // A simultaneous read and write is treated as a read.
                op_q    <= mem_r_en ? OpRead : OpWrite;
                addr_q  <= addr;
                wdata_q <= wr_data;
                cnt_q   <= CntW'(WAIT_CYCLES - 1);
            end else if ((state_q == StWait) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end
            // Hold the completed read so rd_data stays valid until the next read.
            if ((state_q == StDone) && (op_q == OpRead)) begin
                rd_data_q <= rd_data;
            end
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IdxW)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .idx   (arr_idx),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the MEM stage of the 5-stage pipeline.
- Serves the read/write requests that EXE2MEM_reg presents: MEM_R_EN, MEM_W_EN, ALU address and Val_Rm store data.
- Every access takes a programmable multi-cycle latency. `ready` is the handshake; it feeds the hazard/freeze logic so the pipeline stalls until the access completes.

Parameters:
- DEPTH_WORDS, 64: number of 32-bit words in the array; must be a power of 2.
- ADDR_BASE, 1024: byte address that maps to word 0.
- WAIT_CYCLES, 3: cycles between request acceptance and the access being performed; minimum 1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- mem_r_en  in  1  read request; held stable by the requester until `ready` is high.
- mem_w_en  in  1  write request; same hold rule as mem_r_en.
- addr  in  32  byte address; held stable with the request.
- wr_data  in  32  store data; held stable with the request.
- rd_data  out  32  registered read data.
- ready  out  1  high means no request is pending, or the current access is complete this cycle.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counter=0, rd_data=0, latched op/addr/data cleared. Array contents are not reset.
- Internal signal: req = mem_r_en | mem_w_en.
- ready is combinational: ready = (state==IDLE && !req) || state==DONE.
  - A new request drops ready in the same cycle it appears, so the pipeline freezes immediately.
- State IDLE:
  - With req: latch op (read if mem_r_en, else write), addr and wr_data; counter <= WAIT_CYCLES-1; go to WAIT.
  - Without req: stay in IDLE.
- State WAIT:
  - counter != 0: decrement.
  - counter == 0: perform the access, then go to DONE.
    - Write: array[idx] <= latched data.
    - Read: rd_data <= array[idx].
- State DONE: ready=1 for exactly one cycle; go to IDLE unconditionally.
  - The request is consumed here and the pipeline advances on this edge.
  - A request seen in the following IDLE cycle is a new one.
- Latency: request first visible at cycle 0 gives ready=1 at cycle WAIT_CYCLES+1, with rd_data already valid in that cycle. Back-to-back requests cost WAIT_CYCLES+2 cycles each.
- Index computation: idx = ((addr - ADDR_BASE) >> 2), truncated to log2(DEPTH_WORDS) bits.
  - addr[1:0] is ignored; no byte or halfword access.
  - Subtraction is 32-bit and wraps.
- Read and write asserted together: treated as a read; no write occurs.
- rd_data holds its value until the next read completes; writes never change it.
- Requester drops req while in WAIT: the access still completes as latched (requester protocol violation, not checked).
- Reset mid-operation: the access is aborted. An in-flight write is not performed, and ready returns to the IDLE rule.

Optional Feature:
- Macro: DMEM_RANGE_CHECK_EN.
- When defined:
  - Adds output port `err` (1 bit, reset 0).
  - On the DONE cycle, err=1 if (addr - ADDR_BASE) >= DEPTH_WORDS*4 as unsigned; otherwise err=0. err is 0 outside DONE.
  - Out-of-range write: dropped. Out-of-range read: rd_data <= 0.
- When not defined: no `err` port; addresses wrap modulo DEPTH_WORDS per the index computation above.

Decomposition:
- Package dmem_pkg holds:
  - state enum {IDLE, WAIT, DONE}, 2 bits;
  - default constants for DEPTH_WORDS, ADDR_BASE and WAIT_CYCLES;
  - a function computing the word index.
- Sub-module dmem_array:
  - single-port synchronous RAM, DEPTH_WORDS x 32;
  - inputs we, idx, wdata; output rdata registered on clk;
  - no reset.
- The responder holds the FSM, counter and latches.

Test Plan:
- Reset, then idle inputs -> ready=1 and rd_data=0 on every cycle.
- Write addr=1024, wr_data=0xDEADBEEF at cycle 0, defaults -> ready=0 in cycles 0-3, ready=1 in cycle 4, back to 1 with req removed.
- Read addr=1024 after that write -> rd_data=0xDEADBEEF in the cycle ready=1, held afterwards.
- mem_r_en and mem_w_en both high, addr=1028, wr_data=0x1 -> read performed; a later read of 1028 does not return 0x1.
- rst=0 pulsed during WAIT of a write to 1032 with 0x55 -> ready rule restarts from IDLE; a subsequent read of 1032 does not return 0x55 unless it was previously written.
- With DMEM_RANGE_CHECK_EN, write to addr=1024+256 (DEPTH_WORDS=64) -> err=1 in the DONE cycle, array unchanged. Without the macro, the same write lands at word 0.
